// File: rtl/updown_counter.sv
// updown_counter: up/down modulo counter with load, clear and sticky overflow; saturation enabled by UPDOWN_COUNTER_SAT_EN
module updown_counter #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             enable,
  input  logic             dir,
`ifdef UPDOWN_COUNTER_SAT_EN
  input  logic             sat,
`endif
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt_out,
  output logic             wrap,
  output logic             zero,
  output logic             at_max,
  output logic             ovf
);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d, ovf_q, ovf_d;
  logic [WIDTH:0]   up_v, dn_v;
  logic             bnd, step, sat_m;
  // next-state: clr > load > enable > hold; the extra bit exposes carry past MAX and borrow below 0
  always_comb begin
`ifdef UPDOWN_COUNTER_SAT_EN
    sat_m  = sat;
`else
    sat_m  = 1'b0;
`endif
    up_v   = {1'b0, cnt_q} + (WIDTH+1)'(1);
    dn_v   = {1'b0, cnt_q} - (WIDTH+1)'(1);
    bnd    = dir ? (up_v > MAX_W) : dn_v[WIDTH];
    step   = enable & ~clr & ~load;
    cnt_d  = clr ? '0 :
             load ? (({1'b0, cnt_in} > MAX_W) ? MAX_W[WIDTH-1:0] : cnt_in) :
             !enable ? cnt_q :
             !bnd ? (dir ? up_v[WIDTH-1:0] : dn_v[WIDTH-1:0]) :
             (dir ^ sat_m) ? '0 : MAX_W[WIDTH-1:0];
    wrap_d = step & bnd;
    ovf_d  = (step & bnd) | (ovf_q & ~ovf_clr);
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end
  assign cnt_out = cnt_q;
  assign wrap    = wrap_q;
  assign ovf     = ovf_q;
  assign zero    = cnt_q == '0;
  assign at_max  = cnt_q == MAX_W[WIDTH-1:0];
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed and random checks of updown_counter (MAX_VAL=9 and full range) against an integer model
module tb_updown_counter;
  logic clk = 0, rst = 0, clr = 0, load = 0, enable = 0, dir = 1, sat = 0, ovf_clr = 0;
  logic [4:0] cnt_in = '0;
  logic [4:0] cnt_a, cnt_b;
  logic wrap_a, zero_a, max_a, ovf_a, wrap_b, zero_b, max_b, ovf_b;
  int ca, cb, vectors, miscompares;
  bit wa, wb, oa, ob;

  updown_counter #(.WIDTH(5), .MAX_VAL(9)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .enable(enable), .dir(dir),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .cnt_in(cnt_in), .ovf_clr(ovf_clr),
    .cnt_out(cnt_a), .wrap(wrap_a), .zero(zero_a), .at_max(max_a), .ovf(ovf_a));

  updown_counter #(.WIDTH(5), .MAX_VAL(31)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .enable(enable), .dir(dir),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .cnt_in(cnt_in), .ovf_clr(ovf_clr),
    .cnt_out(cnt_b), .wrap(wrap_b), .zero(zero_b), .at_max(max_b), .ovf(ovf_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // one edge of the behavioural counter over the range 0..mx
  function automatic void mdl(input int mx, input bit s, inout int c, inout bit w, inout bit o);
    bit b = 0;
    if (clr) begin c = 0; w = 0; end
    else if (load) begin c = (int'(cnt_in) > mx) ? mx : int'(cnt_in); w = 0; end
    else if (enable) begin
      b = dir ? (c == mx) : (c == 0);
      if (!b) c = dir ? c + 1 : c - 1;
      else if (s) c = dir ? mx : 0;
      else c = dir ? 0 : mx;
      w = b;
    end else w = 0;
    o = b ? 1'b1 : (ovf_clr ? 1'b0 : o);
  endfunction

  function automatic logic [8:0] ev(input int mx, input int c, input bit w, input bit o);
    return {5'(c), w, c == 0, c == mx, o};
  endfunction

  task automatic tick();
    bit s;
`ifdef UPDOWN_COUNTER_SAT_EN
    s = sat;
`else
    s = 1'b0;
`endif
    mdl(9, s, ca, wa, oa);
    mdl(31, s, cb, wb, ob);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; load = 0; enable = 0; dir = 1; sat = 0; ovf_clr = 0; cnt_in = '0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({cnt_a, wrap_a, zero_a, max_a, ovf_a} !== 9'b00000_0_1_0_0) begin
      miscompares++;
      $display("FAIL reset_initial: got %b want %b", {cnt_a, wrap_a, zero_a, max_a, ovf_a}, 9'b00000_0_1_0_0);
    end
    rst = 1;
    ca = 0; cb = 0; wa = 0; wb = 0; oa = 0; ob = 0;
    @(posedge clk); #1;
    enable = 1; dir = 1;
    repeat (7) tick();
    vectors++;
    if (cnt_a !== 5'd7) begin
      miscompares++;
      $display("FAIL reset_precount: got %0d want 7", cnt_a);
    end
    #2 rst = 0;
    #1;
    ca = 0; cb = 0; wa = 0; wb = 0; oa = 0; ob = 0;
    vectors++;
    if ({cnt_a, wrap_a, zero_a, max_a, ovf_a} !== 9'b00000_0_1_0_0 || cnt_b !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %b/%0d want %b/0", {cnt_a, wrap_a, zero_a, max_a, ovf_a}, cnt_b, 9'b00000_0_1_0_0);
    end
    #2 rst = 1;
    repeat (3) tick();
    vectors++;
    if (cnt_a !== 5'd3 || cnt_b !== 5'd3) begin
      miscompares++;
      $display("FAIL reset_resume: got %0d/%0d want 3/3", cnt_a, cnt_b);
    end
  endtask

  task automatic test_up_wrap();
    idle(); clr = 1; tick();
    clr = 0; enable = 1; dir = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if ({cnt_a, wrap_a, zero_a, max_a, ovf_a} !== ev(9, ca, wa, oa) || cnt_a !== 5'(i % 10) || wrap_a !== (i == 10)) begin
        miscompares++;
        $display("FAIL up_wrap step %0d: got %b want %b", i, {cnt_a, wrap_a, zero_a, max_a, ovf_a}, ev(9, ca, wa, oa));
      end
    end
    enable = 0; tick(); tick();
    vectors++;
    if (ovf_a !== 1'b1 || wrap_a !== 1'b0) begin
      miscompares++;
      $display("FAIL up_wrap_sticky: got ovf=%b wrap=%b want ovf=1 wrap=0", ovf_a, wrap_a);
    end
  endtask

  task automatic test_down_wrap();
    idle(); ovf_clr = 1; tick();
    ovf_clr = 0; load = 1; cnt_in = 5'd1; tick();
    load = 0; enable = 1; dir = 0; tick();
    vectors++;
    if (cnt_a !== 5'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL down_to_zero: got cnt=%0d wrap=%b ovf=%b want 0/0/0", cnt_a, wrap_a, ovf_a);
    end
    tick();
    vectors++;
    if (cnt_a !== 5'd9 || wrap_a !== 1'b1 || ovf_a !== 1'b1 || max_a !== 1'b1) begin
      miscompares++;
      $display("FAIL down_wrap: got cnt=%0d wrap=%b ovf=%b want 9/1/1", cnt_a, wrap_a, ovf_a);
    end
    enable = 0; ovf_clr = 1; tick();
    vectors++;
    if (ovf_a !== 1'b0 || wrap_a !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr: got ovf=%b wrap=%b want 0/0", ovf_a, wrap_a);
    end
    ovf_clr = 0; load = 1; cnt_in = 5'd0; tick();
    load = 0; enable = 1; dir = 0; ovf_clr = 1; tick();
    vectors++;
    if (ovf_a !== 1'b1 || cnt_a !== 5'd9 || {cnt_b, wrap_b, zero_b, max_b, ovf_b} !== ev(31, cb, wb, ob)) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d want 1/9", ovf_a, cnt_a);
    end
  endtask

`ifdef UPDOWN_COUNTER_SAT_EN
  task automatic test_saturate();
    logic [1:0] ws [3];
    ws[0] = 2'b00; ws[1] = 2'b01; ws[2] = 2'b01;
    idle(); load = 1; cnt_in = 5'd8; tick();
    load = 0; enable = 1; dir = 1; sat = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cnt_a !== 5'd9 || {1'b0, wrap_a} !== ws[i] || {cnt_b, wrap_b, zero_b, max_b, ovf_b} !== ev(31, cb, wb, ob)) begin
        miscompares++;
        $display("FAIL sat_up step %0d: got cnt=%0d wrap=%b want 9/%b", i, cnt_a, wrap_a, ws[i][0]);
      end
    end
    enable = 0; load = 1; cnt_in = 5'd1; tick();
    load = 0; enable = 1; dir = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cnt_a !== 5'd0 || {1'b0, wrap_a} !== ws[i] || zero_a !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_down step %0d: got cnt=%0d wrap=%b want 0/%b", i, cnt_a, wrap_a, ws[i][0]);
      end
    end
  endtask
`endif

  task automatic test_priority();
    idle(); load = 1; cnt_in = 5'd3; tick();
    clr = 1; load = 1; enable = 1; cnt_in = 5'd5; tick();
    vectors++;
    if (cnt_a !== 5'd0 || cnt_b !== 5'd0 || wrap_a !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_clr: got %0d/%0d want 0/0", cnt_a, cnt_b);
    end
    clr = 0; tick();
    vectors++;
    if (cnt_a !== 5'd5 || cnt_b !== 5'd5) begin
      miscompares++;
      $display("FAIL prio_load: got %0d/%0d want 5/5", cnt_a, cnt_b);
    end
    enable = 0; cnt_in = 5'd20; tick();
    vectors++;
    if (cnt_a !== 5'd9 || max_a !== 1'b1 || cnt_b !== 5'd20 || max_b !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clamp: got %0d/%b %0d want 9/1 20", cnt_a, max_a, cnt_b);
    end
  endtask

  task automatic test_full_width();
    idle(); load = 1; cnt_in = 5'd30; tick();
    load = 0; enable = 1; dir = 1; tick();
    vectors++;
    if (cnt_b !== 5'd31 || max_b !== 1'b1 || wrap_b !== 1'b0) begin
      miscompares++;
      $display("FAIL full_up_max: got cnt=%0d at_max=%b want 31/1", cnt_b, max_b);
    end
    tick();
    vectors++;
    if (cnt_b !== 5'd0 || wrap_b !== 1'b1 || zero_b !== 1'b1 || ovf_b !== 1'b1) begin
      miscompares++;
      $display("FAIL full_up_wrap: got cnt=%0d wrap=%b want 0/1", cnt_b, wrap_b);
    end
    dir = 0; tick();
    vectors++;
    if (cnt_b !== 5'd31 || wrap_b !== 1'b1 || {cnt_a, wrap_a, zero_a, max_a, ovf_a} !== ev(9, ca, wa, oa)) begin
      miscompares++;
      $display("FAIL full_down_wrap: got cnt=%0d wrap=%b want 31/1", cnt_b, wrap_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      clr = $urandom_range(0, 19) == 0;
      load = $urandom_range(0, 9) == 0;
      enable = $urandom_range(0, 3) != 0;
      dir = $urandom_range(0, 3) != 0;
      sat = $urandom_range(0, 1) == 1;
      ovf_clr = $urandom_range(0, 7) == 0;
      cnt_in = 5'($urandom);
      tick();
      vectors++;
      if ({cnt_a, wrap_a, zero_a, max_a, ovf_a} !== ev(9, ca, wa, oa) || {cnt_b, wrap_b, zero_b, max_b, ovf_b} !== ev(31, cb, wb, ob)) begin
        miscompares++;
        $display("FAIL random %0d: got %b/%b want %b/%b", i, {cnt_a, wrap_a, zero_a, max_a, ovf_a}, {cnt_b, wrap_b, zero_b, max_b, ovf_b}, ev(9, ca, wa, oa), ev(31, cb, wb, ob));
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
`ifdef UPDOWN_COUNTER_SAT_EN
    test_saturate();
`endif
    test_priority();
    test_full_width();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
